// File: rtl/uart_rx_frame_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_if
// Purpose  : Serial line plus byte/handshake/status bundle of the UART receiver.
// Revision : 1.0
// ============================================================================
interface uart_rx_frame_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx_in,
        input  data_ready,
        output data_out,
        output data_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx_in,
        output data_ready,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame
// Purpose  : 8N1 UART receiver, mid-bit sampling, valid/ready byte output.
// Revision : 1.0
// ============================================================================
module uart_rx_frame #(
    parameter int CLK_DIV = 868
) (
    input  wire logic        clk,
    input  wire logic        rst,
    uart_rx_frame_if.master  rx_if
);

    localparam int c_BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_BAUD_W-1:0] c_HALF = c_BAUD_W'(CLK_DIV / 2 - 1);
    localparam logic [c_BAUD_W-1:0] c_FULL = c_BAUD_W'(CLK_DIV - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic                r_rx_meta;
    logic                r_rx_s;
    logic                r_rx_d;
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_data;
    logic                r_valid;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_fall;
    logic                w_half_hit;
    logic                w_full_hit;
    logic                w_busy;
    logic                w_baud_clr;
    logic                w_start_ok;
    logic                w_bit_take;
    logic                w_load;
    logic                w_ferr;

    assign w_fall     = ~r_rx_s & r_rx_d;
    assign w_half_hit = (r_baud == c_HALF);
    assign w_full_hit = (r_baud == c_FULL);

    // Synchronizer idles high so a line held low through reset is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx_if.rx_in;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_fall) w_next_state = c_ST_START;
            c_ST_START: if (w_half_hit) w_next_state = r_rx_s ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:  if (w_full_hit && (r_bit_cnt == 3'd7)) w_next_state = c_ST_STOP;
            c_ST_STOP:  if (w_full_hit) w_next_state = c_ST_IDLE;
            default:    w_next_state = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = 1'b1;
        w_baud_clr = 1'b0;
        w_start_ok = 1'b0;
        w_bit_take = 1'b0;
        w_load     = 1'b0;
        w_ferr     = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_busy     = 1'b0;
                w_baud_clr = 1'b1;
            end
            c_ST_START: begin
                w_baud_clr = w_half_hit;
                w_start_ok = w_half_hit & ~r_rx_s;
            end
            c_ST_DATA: begin
                w_baud_clr = w_full_hit;
                w_bit_take = w_full_hit;
            end
            c_ST_STOP: begin
                w_baud_clr = w_full_hit;
                w_load     = w_full_hit & r_rx_s;
                w_ferr     = w_full_hit & ~r_rx_s;
            end
            default: begin
                w_busy     = 1'b0;
                w_baud_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud    <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            r_baud <= w_baud_clr ? '0 : r_baud + c_BAUD_W'(1);
            if (w_start_ok) begin
                r_bit_cnt <= 3'd0;
            end else if (w_bit_take) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_bit_take) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end
        end
    end

    // A load in a handshake cycle replaces a consumed byte, so no overrun then
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_overrun   <= w_load & r_valid & ~rx_if.data_ready;
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_if.data_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.data_out   = r_data;
    assign rx_if.data_valid = r_valid;
    assign rx_if.frame_err  = r_frame_err;
    assign rx_if.overrun    = r_overrun;
    assign rx_if.busy       = w_busy;

endmodule
`default_nettype wire
